rs232rx: RTL

RS232RX -- requirements
Module: rs232rx

---
 rtl/rs232rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rs232rx.sv
// rs232rx - 8N1 asynchronous serial receiver with a one-entry holding stage.
//
// The line is brought into the clock domain by a two-flop synchronizer. A
// five-state FSM finds the start bit, samples each bit in its centre using a
// sign-bit down-counter, and hands finished bytes to a valid/ready holding
// register.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous, active-high
//   serial_in      raw RS-232 line, idles high
//   data[7:0]      received byte, stable while valid is high
//   valid          data holds a byte that has not been consumed yet
//   ready          consumer takes data in any cycle with valid && ready
//   framing_error  one-cycle pulse when the stop bit is sampled low
//   overrun        one-cycle pulse when a byte is dropped because the
//                  holding register was full and not being consumed
module rs232rx #(
  parameter int frequency   = 0,
  parameter int bps         = 0,
  // A zero line rate only happens with the unconfigured defaults; fall back
  // to a small legal period so the module still elaborates in that case.
  parameter int period      = (bps > 0) ? (frequency + bps / 2) / bps : 4,
  parameter int TTYCLK_SIGN = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int TW = TTYCLK_SIGN + 1;

  // The timer expires when it goes negative, so a load of N-2 gives an
  // action exactly N cycles after the load.
  localparam logic [TW-1:0] HALF_LOAD = TW'(period / 2 - 2);
  localparam logic [TW-1:0] FULL_LOAD = TW'(period - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      sync_q;
  logic            rx;
  logic [TW-1:0]   timer;
  logic            expired;
  logic [3:0]      bit_count;
  logic [7:0]      shift_reg;

  logic            load_half;
  logic            load_full;
  logic            set_count;
  logic            shift_en;
  logic            deliver;
  logic            frame_err;

  // Two-flop synchronizer; reset to the idle level so no false start edge
  // appears on release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end

  assign rx      = sync_q[1];
  assign expired = timer[TTYCLK_SIGN];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx) state_next = START;
      end
      START: begin
        if (expired) state_next = rx ? IDLE : DATA;
      end
      DATA: begin
        if (expired && bit_count == 4'd1) state_next = STOP;
      end
      STOP: begin
        if (expired) state_next = rx ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode: strobes that drive the datapath registers.
  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    set_count = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        load_half = !rx;
      end
      START: begin
        load_full = expired && !rx;
        set_count = expired && !rx;
      end
      DATA: begin
        load_full = expired;
        shift_en  = expired;
      end
      STOP: begin
        deliver   = expired && rx;
        frame_err = expired && !rx;
      end
      default: begin
      end
    endcase
  end

  // Bit timer, bit counter and shift register. The timer stops once it has
  // gone negative, so it can never wrap while waiting in IDLE or WAIT_HIGH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      bit_count <= 4'd0;
      shift_reg <= 8'h00;
    end else begin
      if (load_half) begin
        timer <= HALF_LOAD;
      end else if (load_full) begin
        timer <= FULL_LOAD;
      end else if (!expired) begin
        timer <= timer - TW'(1);
      end

      if (set_count) begin
        bit_count <= 4'd8;
      end else if (shift_en) begin
        bit_count <= bit_count - 4'd1;
      end

      if (shift_en) begin
        shift_reg <= {rx, shift_reg[7:1]};
      end
    end
  end

  // Holding stage. A delivery in the same cycle the old byte is consumed
  // replaces it directly; a delivery into a full, unconsumed register drops
  // the new byte and flags overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data          <= 8'h00;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_err;
      overrun       <= deliver && valid && !ready;
      if (deliver && (!valid || ready)) begin
        data  <= shift_reg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
